// File: rtl/pcs_sync_pkg.sv
// Shared types and constants for the PCS code-group synchronisation block.
package pcs_sync_pkg;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    ACQUIRE_SYNC  = 2'd1,
    SYNC_ACQUIRED = 2'd2
  } sync_state_e;

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  typedef struct packed {
    logic comma;
    logic invalid;
    logic rd_next;  // 1: positive running disparity after this group
  } cg_class_t;

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cg_classify.sv
// Combinational code-group classifier: comma detect, disparity check and
// next running disparity. Holds no state.
module cg_classify
  import pcs_sync_pkg::*;
(
  input  logic [9:0] code_group_i,
  input  logic       rd_i,
  input  logic       in_loss_i,
  output cg_class_t  class_o
);

  logic [3:0] ones;
  logic       disp_neg;
  logic       disp_zero;
  logic       disp_pos;
  logic       comma;
  logic       rd_err;

  always_comb begin
    ones      = popcount10(code_group_i);
    disp_neg  = (ones == 4'd4);
    disp_zero = (ones == 4'd5);
    disp_pos  = (ones == 4'd6);
    comma     = (code_group_i == K28_5_NEG) || (code_group_i == K28_5_POS);

    // Commas re-establish disparity, so they are never flagged for an RD error.
    rd_err = !in_loss_i && !comma && ((disp_pos && rd_i) || (disp_neg && !rd_i));

    class_o.comma   = comma;
    class_o.invalid = !(disp_neg || disp_zero || disp_pos) || rd_err;

    if (in_loss_i && comma) begin
      class_o.rd_next = disp_pos;
    end else if (disp_zero) begin
      class_o.rd_next = rd_i;
    end else begin
      class_o.rd_next = !rd_i;
    end
  end

endmodule

// File: rtl/pcs_sync_fsm_param.sv
// PCS code-group synchronisation FSM (8b/10b receive path).
// Optional SYNC_STATS_EN adds saturating loss/acquire event counters.
module pcs_sync_fsm_param
  import pcs_sync_pkg::*;
#(
  parameter int unsigned N_ACQ  = 3,
  parameter int unsigned N_LOSS = 4,
  parameter int unsigned N_GOOD = 3,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              mr_main_reset,
  input  logic              mr_loopback,
  input  logic              signal_detect,
  input  logic [9:0]        code_group,
  output logic [9:0]        SUDI,
  output logic              code_sync_status,
  output logic              rx_even
`ifdef SYNC_STATS_EN
  ,
  output logic [STAT_W-1:0] loss_cnt,
  output logic [STAT_W-1:0] acq_cnt
`endif
);

  localparam int unsigned AcqW  = $clog2(N_ACQ + 1);
  localparam int unsigned BadW  = $clog2(N_LOSS + 1);
  localparam int unsigned GoodW = $clog2(N_GOOD + 1);

  localparam logic [AcqW-1:0]  AcqLast  = AcqW'(N_ACQ - 1);
  localparam logic [BadW-1:0]  BadLast  = BadW'(N_LOSS - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(N_GOOD - 1);
  localparam logic [AcqW-1:0]  AcqOne   = AcqW'(1);
  localparam logic [BadW-1:0]  BadOne   = BadW'(1);
  localparam logic [GoodW-1:0] GoodOne  = GoodW'(1);

  sync_state_e      state_q, state_d;
  logic [AcqW-1:0]  acq_q, acq_d;
  logic [BadW-1:0]  bad_q, bad_d;
  logic [GoodW-1:0] good_q, good_d;
  logic             rd_q, rd_d;
  logic             rx_even_q, rx_even_d;
  logic             status_q, status_d;
  logic [9:0]       sudi_q;

  cg_class_t cls;
  logic      sigfail;
  logic      cgbad;
  logic      loss_evt;
  logic      acq_evt;

  cg_classify u_classify (
    .code_group_i(code_group),
    .rd_i        (rd_q),
    .in_loss_i   (state_q == LOSS_OF_SYNC),
    .class_o     (cls)
  );

  assign sigfail = !signal_detect && !mr_loopback;
  // A comma arriving while the previous group was even would land in an odd slot.
  assign cgbad   = cls.invalid || (cls.comma && rx_even_q);

  always_comb begin
    state_d   = state_q;
    acq_d     = acq_q;
    bad_d     = bad_q;
    good_d    = good_q;
    rd_d      = cls.rd_next;
    rx_even_d = !rx_even_q;
    loss_evt  = 1'b0;
    acq_evt   = 1'b0;

    if (sigfail) begin
      state_d  = LOSS_OF_SYNC;
      acq_d    = '0;
      bad_d    = '0;
      good_d   = '0;
      rd_d     = rd_q;
      loss_evt = (state_q == SYNC_ACQUIRED);
    end else begin
      unique case (state_q)
        LOSS_OF_SYNC: begin
          if (cls.comma) begin
            rx_even_d = 1'b1;
            acq_d     = AcqOne;
            if (N_ACQ == 1) begin
              state_d = SYNC_ACQUIRED;
              bad_d   = '0;
              good_d  = '0;
              acq_evt = 1'b1;
            end else begin
              state_d = ACQUIRE_SYNC;
            end
          end
        end
        ACQUIRE_SYNC: begin
          if (cgbad) begin
            state_d = LOSS_OF_SYNC;
            acq_d   = '0;
          end else if (cls.comma) begin
            if (acq_q == AcqLast) begin
              state_d = SYNC_ACQUIRED;
              acq_d   = '0;
              bad_d   = '0;
              good_d  = '0;
              acq_evt = 1'b1;
            end else begin
              acq_d = acq_q + AcqOne;
            end
          end
        end
        SYNC_ACQUIRED: begin
          if (cgbad) begin
            good_d = '0;
            if (bad_q == BadLast) begin
              state_d  = LOSS_OF_SYNC;
              bad_d    = '0;
              loss_evt = 1'b1;
            end else begin
              bad_d = bad_q + BadOne;
            end
          end else if (bad_q != '0) begin
            if (good_q == GoodLast) begin
              bad_d  = bad_q - BadOne;
              good_d = '0;
            end else begin
              good_d = good_q + GoodOne;
            end
          end
        end
        default: begin
          state_d = LOSS_OF_SYNC;
          acq_d   = '0;
          bad_d   = '0;
          good_d  = '0;
        end
      endcase
    end

    status_d = (state_d == SYNC_ACQUIRED);
  end

  always_ff @(posedge clk) begin
    if (mr_main_reset) begin
      state_q   <= LOSS_OF_SYNC;
      acq_q     <= '0;
      bad_q     <= '0;
      good_q    <= '0;
      rd_q      <= 1'b0;
      rx_even_q <= 1'b0;
      status_q  <= 1'b0;
      sudi_q    <= '0;
    end else begin
      state_q   <= state_d;
      acq_q     <= acq_d;
      bad_q     <= bad_d;
      good_q    <= good_d;
      rd_q      <= rd_d;
      rx_even_q <= rx_even_d;
      status_q  <= status_d;
      sudi_q    <= code_group;
    end
  end

  assign SUDI             = sudi_q;
  assign code_sync_status = status_q;
  assign rx_even          = rx_even_q;

`ifdef SYNC_STATS_EN
  logic [STAT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [STAT_W-1:0] acq_cnt_q, acq_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    acq_cnt_d  = acq_cnt_q;
    if (loss_evt && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + STAT_W'(1);
    end
    if (acq_evt && (acq_cnt_q != '1)) begin
      acq_cnt_d = acq_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mr_main_reset) begin
      loss_cnt_q <= '0;
      acq_cnt_q  <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
      acq_cnt_q  <= acq_cnt_d;
    end
  end

  assign loss_cnt = loss_cnt_q;
  assign acq_cnt  = acq_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = loss_evt ^ acq_evt ^ (STAT_W == 0);
`endif

endmodule

// File: tb/tb_pcs_sync_fsm_param.sv
// Directed bench for pcs_sync_fsm_param: stimulus pushes expected outputs into
// a queue, a monitor pops and compares one entry per clock.
module tb_pcs_sync_fsm_param;

  localparam logic [9:0] CP = 10'b1100000101;  // K28.5, RD+ form
  localparam logic [9:0] DN = 10'b1010010110;  // neutral data group
  localparam logic [9:0] XB = 10'b1111111111;  // invalid group

  logic        clk = 1'b0;
  logic        mr_main_reset = 1'b1;
  logic        mr_loopback = 1'b0;
  logic        signal_detect = 1'b1;
  logic [9:0]  code_group = XB;
  logic [9:0]  SUDI;
  logic        code_sync_status;
  logic        rx_even;
`ifdef SYNC_STATS_EN
  logic [15:0] loss_cnt;
  logic [15:0] acq_cnt;
`endif

  typedef struct {
    logic [9:0] sudi;
    logic       status;
    logic       even;
    logic       chk_even;
    int         test;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_test = 0;
  int   step_idx = 0;

  always #5 clk = ~clk;

  pcs_sync_fsm_param #(
    .N_ACQ (3),
    .N_LOSS(4),
    .N_GOOD(3),
    .STAT_W(16)
  ) dut (
    .clk             (clk),
    .mr_main_reset   (mr_main_reset),
    .mr_loopback     (mr_loopback),
    .signal_detect   (signal_detect),
    .code_group      (code_group),
    .SUDI            (SUDI),
    .code_sync_status(code_sync_status),
    .rx_even         (rx_even)
`ifdef SYNC_STATS_EN
    ,
    .loss_cnt        (loss_cnt),
    .acq_cnt         (acq_cnt)
`endif
  );

  task automatic step(input logic [9:0] cg, input logic rst, input logic sd, input logic lb,
                      input logic st, input logic ev, input logic chk_ev);
    exp_t e;
    @(negedge clk);
    mr_main_reset = rst;
    signal_detect = sd;
    mr_loopback   = lb;
    code_group    = cg;
    e.sudi     = rst ? 10'd0 : cg;
    e.status   = st;
    e.even     = ev;
    e.chk_even = chk_ev;
    e.test     = cur_test;
    e.idx      = step_idx;
    step_idx++;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int t);
    cur_test = t;
    step_idx = 0;
    step(XB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(XB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // From LOSS_OF_SYNC after reset (rx_even=0): ends in sync with rx_even=1.
  task automatic acquire(input logic sd, input logic lb);
    step(CP, 1'b0, sd, lb, 1'b0, 1'b1, 1'b1);
    step(DN, 1'b0, sd, lb, 1'b0, 1'b0, 1'b1);
    step(CP, 1'b0, sd, lb, 1'b0, 1'b1, 1'b1);
    step(DN, 1'b0, sd, lb, 1'b0, 1'b0, 1'b1);
    step(CP, 1'b0, sd, lb, 1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: every clock the DUT presents a new registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (SUDI !== e.sudi) begin
          n_bad++;
          $display("FAIL t%0d s%0d SUDI got %b need %b", e.test, e.idx, SUDI, e.sudi);
        end
        n_cmp++;
        if (code_sync_status !== e.status) begin
          n_bad++;
          $display("FAIL t%0d s%0d status got %b need %b", e.test, e.idx,
                   code_sync_status, e.status);
        end
        if (e.chk_even) begin
          n_cmp++;
          if (rx_even !== e.even) begin
            n_bad++;
            $display("FAIL t%0d s%0d rx_even got %b need %b", e.test, e.idx, rx_even, e.even);
          end
        end
      end
    end
  end

  initial begin
    // 1: reset, then LOSS_OF_SYNC toggles rx_even on a data group
    do_reset(1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // 2: three even-aligned commas acquire sync
    do_reset(2);
    acquire(1'b1, 1'b0);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // 3: comma on an odd slot during acquisition drops back to LOSS_OF_SYNC
    do_reset(3);
    step(CP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(CP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(CP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(CP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(CP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(CP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 4: four bad groups separated by single good groups lose sync
    do_reset(4);
    acquire(1'b1, 1'b0);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // 5: three good groups recover one bad; three more bad keep sync
    do_reset(5);
    acquire(1'b1, 1'b0);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(XB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 6: signal_detect low loses sync unless loopback masks it
    do_reset(6);
    acquire(1'b1, 1'b0);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(DN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    acquire(1'b0, 1'b1);
    step(DN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(DN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d need 0", exp_q.size());
    end
`ifdef SYNC_STATS_EN
    n_cmp++;
    if (loss_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL loss_cnt got %0d need 1", loss_cnt);
    end
    n_cmp++;
    if (acq_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL acq_cnt got %0d need 2", acq_cnt);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
